// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, ALU op classes, opcodes and the decoded
// control bundle used by both the ID decoder and the ID/EX register.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_ITYPE = 2'b11
  } aluop_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic   reg_write;
    logic   mem_to_reg;
    logic   mem_read;
    logic   mem_write;
    logic   alu_src;
    aluop_e alu_op;
  } ctrl_t;
endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: async active-low reset, load enable and
// a synchronous clear that only acts on edges where the register loads.
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) data_d = clr_i ? '0 : d_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q_o = data_q;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, flush, saturating bubble counter and
// the load-use hazard flag seen by the hazard unit.
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             ALUSrc_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [XLEN-1:0]  RS1data_i,
  input  logic [XLEN-1:0]  RS2data_i,
  input  logic [XLEN-1:0]  Imm_i,
  input  logic [9:0]       funct_i,
  input  logic [RA_W-1:0]  RS1addr_i,
  input  logic [RA_W-1:0]  RS2addr_i,
  input  logic [RA_W-1:0]  RDaddr_i,
  output logic             valid_o,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             ALUSrc_o,
  output logic [1:0]       ALUOp_o,
  output logic [XLEN-1:0]  RS1data_o,
  output logic [XLEN-1:0]  RS2data_o,
  output logic [XLEN-1:0]  Imm_o,
  output logic [9:0]       funct_o,
  output logic [RA_W-1:0]  RS1addr_o,
  output logic [RA_W-1:0]  RS2addr_o,
  output logic [RA_W-1:0]  RDaddr_o,
  output logic             load_use_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);
  import cpu_pkg::*;

  localparam int CW = 1 + $bits(ctrl_t) + RA_W;
  localparam int DW = 3*XLEN + 10 + 2*RA_W;

  ctrl_t           ctrl_in, ctrl_out;
  logic [CW-1:0]   ctl_q;
  logic [DW-1:0]   dat_q;
  logic            load_en, bubble;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Flush overrides stall; an invalid ID slot is stored exactly like a flush.
  assign load_en = flush_i | ~stall_i;
  assign bubble  = flush_i | (~stall_i & ~valid_i);

  always_comb begin
    ctrl_in            = '0;
    ctrl_in.reg_write  = RegWrite_i;
    ctrl_in.mem_to_reg = MemtoReg_i;
    ctrl_in.mem_read   = MemRead_i;
    ctrl_in.mem_write  = MemWrite_i;
    ctrl_in.alu_src    = ALUSrc_i;
    ctrl_in.alu_op     = aluop_e'(ALUOp_i);
  end

  pipe_field_reg #(.W(CW)) u_ctl (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (load_en),
    .clr_i (bubble),
    .d_i   ({valid_i, ctrl_in, RDaddr_i}),
    .q_o   (ctl_q)
  );

  pipe_field_reg #(.W(DW)) u_dat (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (load_en),
    .clr_i (1'b0),
    .d_i   ({RS1data_i, RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i}),
    .q_o   (dat_q)
  );

  assign {valid_o, ctrl_out, RDaddr_o} = ctl_q;
  assign {RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o} = dat_q;
  assign RegWrite_o = ctrl_out.reg_write;
  assign MemtoReg_o = ctrl_out.mem_to_reg;
  assign MemRead_o  = ctrl_out.mem_read;
  assign MemWrite_o = ctrl_out.mem_write;
  assign ALUSrc_o   = ctrl_out.alu_src;
  assign ALUOp_o    = ctrl_out.alu_op;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) bubble_cnt_q <= '0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt_o = bubble_cnt_q;

  // x0 is hard-wired zero, so a load targeting it can never create a hazard.
  assign load_use_o = valid_o & MemRead_o & (RDaddr_o != '0) &
                      ((RDaddr_o == RS1addr_i) | (RDaddr_o == RS2addr_i));
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg; small counter width so saturation is reachable.
module tb_id_ex_pipe_reg;
  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic valid, rw, m2r, mr, mw, as;
    logic [1:0] op;
    logic [XLEN-1:0] r1d, r2d, imm;
    logic [9:0] f;
    logic [RA_W-1:0] r1a, r2a, rda;
    logic [CNT_W-1:0] cnt;
  } out_t;

  logic clk = 1'b0, rst_i = 1'b0;
  logic stall_i, flush_i, valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
  logic [1:0] ALUOp_i;
  logic [XLEN-1:0] RS1data_i, RS2data_i, Imm_i;
  logic [9:0] funct_i;
  logic [RA_W-1:0] RS1addr_i, RS2addr_i, RDaddr_i;
  logic valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, load_use_o;
  logic [1:0] ALUOp_o;
  logic [XLEN-1:0] RS1data_o, RS2data_o, Imm_o;
  logic [9:0] funct_o;
  logic [RA_W-1:0] RS1addr_o, RS2addr_o, RDaddr_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  out_t act, exp_s, got;
  out_t sb[$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .funct_i(funct_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .valid_o(valid_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
    .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o), .funct_o(funct_o),
    .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
    .load_use_o(load_use_o), .bubble_cnt_o(bubble_cnt_o)
  );

  assign act = '{valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
                 RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
                 bubble_cnt_o};

  // Reference behaviour of one clock edge, from the current inputs.
  function automatic out_t mdl(out_t c);
    out_t n = c;
    logic bub;
    if (flush_i || !stall_i) begin
      bub = flush_i || !valid_i;
      n.r1d = RS1data_i; n.r2d = RS2data_i; n.imm = Imm_i; n.f = funct_i;
      n.r1a = RS1addr_i; n.r2a = RS2addr_i;
      if (bub) begin
        n.valid = 0; n.rw = 0; n.m2r = 0; n.mr = 0; n.mw = 0; n.as = 0; n.op = 0; n.rda = 0;
        if (c.cnt != '1) n.cnt = c.cnt + 1'b1;
      end else begin
        n.valid = 1; n.rw = RegWrite_i; n.m2r = MemtoReg_i; n.mr = MemRead_i;
        n.mw = MemWrite_i; n.as = ALUSrc_i; n.op = ALUOp_i; n.rda = RDaddr_i;
      end
    end
    return n;
  endfunction

  task automatic drv(input logic v, rw, m2r, mr, mw, as, input logic [1:0] op,
                     input logic [XLEN-1:0] a, b, imm, input logic [9:0] f,
                     input logic [RA_W-1:0] r1, r2, rd);
    valid_i = v; RegWrite_i = rw; MemtoReg_i = m2r; MemRead_i = mr; MemWrite_i = mw;
    ALUSrc_i = as; ALUOp_i = op; RS1data_i = a; RS2data_i = b; Imm_i = imm;
    funct_i = f; RS1addr_i = r1; RS2addr_i = r2; RDaddr_i = rd;
  endtask

  task automatic drv_rand();
    drv($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
        $urandom_range(0,1), $urandom_range(0,1), 2'($urandom_range(0,3)), $urandom,
        $urandom, $urandom, 10'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
  endtask

  task automatic step(input string tag);
    logic exp_lu;
    exp_s = mdl(exp_s);
    sb.push_back(exp_s);
    @(posedge clk); #1;
    got = sb.pop_front();
    total++;
    if (act !== got) begin
      bad++; $display("FAIL %s: got=%h want=%h", tag, act, got);
    end
    exp_lu = got.valid & got.mr & (got.rda != 0) & ((got.rda == RS1addr_i) | (got.rda == RS2addr_i));
    total++;
    if (load_use_o !== exp_lu) begin
      bad++; $display("FAIL %s_load_use: got=%b want=%b", tag, load_use_o, exp_lu);
    end
  endtask

  task automatic test_reset();
    stall_i = 1; flush_i = 1;
    drv(1, 1, 1, 1, 1, 1, 2'b11, '1, '1, '1, '1, '1, '1, '1);
    rst_i = 0; #2;
    total++;
    if (act !== '0) begin bad++; $display("FAIL reset_async: got=%h want=0", act); end
    repeat (3) @(posedge clk);
    #1; total++;
    if (act !== '0 || load_use_o !== 1'b0) begin
      bad++; $display("FAIL reset_held: got=%h lu=%b want=0", act, load_use_o);
    end
    rst_i = 1; #1; total++;
    if (act !== '0) begin bad++; $display("FAIL reset_release: got=%h want=0", act); end
    exp_s = '0; sb.delete();
    step("post_reset_flush");
  endtask

  task automatic test_load_add();
    logic [CNT_W-1:0] c0;
    stall_i = 0; flush_i = 0; c0 = exp_s.cnt;
    drv(1, 1, 0, 0, 0, 0, 2'b10, 32'd5, 32'd7, 32'd0, 10'h000, 5'd1, 5'd2, 5'd3);
    step("load_add");
    total++;
    if (RS1data_o !== 32'd5 || RS2data_o !== 32'd7 || RDaddr_o !== 5'd3 ||
        ALUOp_o !== 2'b10 || bubble_cnt_o !== c0) begin
      bad++; $display("FAIL add_fields: rs1=%0d rs2=%0d rd=%0d op=%b cnt=%0d want 5 7 3 10 %0d",
                      RS1data_o, RS2data_o, RDaddr_o, ALUOp_o, bubble_cnt_o, c0);
    end
  endtask

  task automatic test_load_use();
    logic [RA_W-1:0] a1 [3] = '{5'd5, 5'd6, 5'd6};
    logic [RA_W-1:0] a2 [3] = '{5'd0, 5'd5, 5'd7};
    logic            w  [3] = '{1'b1, 1'b1, 1'b0};
    stall_i = 0; flush_i = 0;
    drv(1, 1, 1, 1, 0, 1, 2'b00, 32'd100, 32'd0, 32'd4, 10'h002, 5'd1, 5'd0, 5'd5);
    step("load_lw_x5");
    for (int i = 0; i < 3; i++) begin
      RS1addr_i = a1[i]; RS2addr_i = a2[i]; #1;
      total++;
      if (load_use_o !== w[i]) begin
        bad++; $display("FAIL load_use_x5_%0d: got=%b want=%b", i, load_use_o, w[i]);
      end
    end
    drv(1, 1, 1, 1, 0, 1, 2'b00, 32'd100, 32'd0, 32'd4, 10'h002, 5'd1, 5'd0, 5'd0);
    step("load_lw_x0");
    RS1addr_i = 0; RS2addr_i = 0; #1;
    total++;
    if (load_use_o !== 1'b0) begin
      bad++; $display("FAIL load_use_x0: got=%b want=0", load_use_o);
    end
  endtask

  task automatic test_stall();
    logic [CNT_W-1:0] c0;
    stall_i = 0; flush_i = 0;
    drv(1, 0, 0, 0, 1, 1, 2'b00, 32'hCAFE, 32'hBEEF, 32'h10, 10'h3FF, 5'd8, 5'd9, 5'd10);
    step("pre_stall");
    c0 = exp_s.cnt;
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      drv_rand(); valid_i = 0;
      step("stall_hold");
    end
    total++;
    if (RS1data_o !== 32'hCAFE || bubble_cnt_o !== c0 || MemWrite_o !== 1'b1) begin
      bad++; $display("FAIL stall_values: rs1=%h cnt=%0d mw=%b want cafe %0d 1",
                      RS1data_o, bubble_cnt_o, MemWrite_o, c0);
    end
    stall_i = 0;
  endtask

  task automatic test_flush_stall();
    logic [CNT_W-1:0] c0;
    c0 = exp_s.cnt;
    stall_i = 1; flush_i = 1;
    drv(1, 1, 0, 1, 0, 0, 2'b01, 32'd1, 32'd2, 32'd3, 10'h011, 5'd4, 5'd5, 5'd9);
    step("flush_stall");
    total++;
    if (valid_o !== 1'b0 || RegWrite_o !== 1'b0 || RDaddr_o !== 5'd0 || bubble_cnt_o !== c0 + 1'b1) begin
      bad++; $display("FAIL flush_fields: v=%b rw=%b rd=%0d cnt=%0d want 0 0 0 %0d",
                      valid_o, RegWrite_o, RDaddr_o, bubble_cnt_o, c0 + 1'b1);
    end
    stall_i = 0; flush_i = 0;
  endtask

  task automatic test_invalid_bubble();
    stall_i = 0; flush_i = 0;
    drv(0, 1, 1, 1, 1, 1, 2'b11, 32'd9, 32'd9, 32'd9, 10'h1, 5'd3, 5'd4, 5'd7);
    step("invalid_bubble");
    total++;
    if (RegWrite_o !== 1'b0 || MemRead_o !== 1'b0 || MemWrite_o !== 1'b0 || ALUOp_o !== 2'b00) begin
      bad++; $display("FAIL invalid_ctrl: rw=%b mr=%b mw=%b op=%b want 0 0 0 00",
                      RegWrite_o, MemRead_o, MemWrite_o, ALUOp_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      drv_rand();
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 6) == 0);
      step("back_to_back");
    end
    stall_i = 0; flush_i = 0;
  endtask

  task automatic test_reset_mid_stall();
    stall_i = 0; flush_i = 0;
    drv(1, 1, 0, 1, 0, 0, 2'b00, 32'd11, 32'd22, 32'd33, 10'h5, 5'd1, 5'd2, 5'd6);
    step("pre_reset_load");
    stall_i = 1; flush_i = 1; #2;
    rst_i = 0; #1;
    total++;
    if (act !== '0) begin bad++; $display("FAIL reset_mid_stall: got=%h want=0", act); end
    @(posedge clk); #1;
    rst_i = 1; stall_i = 0; flush_i = 0;
    exp_s = '0; sb.delete();
  endtask

  task automatic test_saturate();
    int n = 0;
    stall_i = 0; flush_i = 0;
    drv(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    while (exp_s.cnt != CNT_W'(14) && n < 40) begin
      step("preload_cnt"); n++;
    end
    total++;
    if (bubble_cnt_o !== CNT_W'(14)) begin
      bad++; $display("FAIL preload_cnt: got=%0d want=14", bubble_cnt_o);
    end
    step("sat_bubble_1");
    step("sat_bubble_2");
    total++;
    if (bubble_cnt_o !== '1) begin
      bad++; $display("FAIL saturate: got=%0d want=%0d", bubble_cnt_o, (1 << CNT_W) - 1);
    end
    flush_i = 1; step("sat_hold"); flush_i = 0;
    total++;
    if (bubble_cnt_o !== '1) begin
      bad++; $display("FAIL saturate_hold: got=%0d want=%0d", bubble_cnt_o, (1 << CNT_W) - 1);
    end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_load_use();
    test_stall();
    test_flush_stall();
    test_invalid_bubble();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
